// File: rtl/stack_unit_pkg.sv
// Shared constants and small types for the stack unit.
// Build option: define STACK_UNIT_ERR_EN to enable the sticky err flag.
package stack_unit_pkg;

  localparam int STACK_WIDTH = 32;
  localparam int STACK_DEPTH = 128;
  localparam int STACK_AW    = $clog2(STACK_DEPTH);

  // Raw request decode of push/pop (hold/clear qualify it separately).
  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_PUSH = 2'b01,
    OP_POP  = 2'b10,
    OP_SWAP = 2'b11   // push and pop together: replace top / pass-through
  } op_e;

  // Where the visible q comes from: the RAM read register or a local register
  // (used for the zero on underflow/reset and for the empty pass-through).
  typedef enum logic {
    Q_SRC_REG = 1'b0,
    Q_SRC_RAM = 1'b1
  } q_src_e;

  function automatic op_e decode_op(input logic push, input logic pop);
    return op_e'({pop, push});
  endfunction

endpackage

// File: rtl/stack_ram.sv
// Single-clock storage for the stack: one write port, one registered read
// port with read enable. Reads return the old contents on a same-address
// write (read-first), which the replace-top operation relies on.
module stack_ram #(
  parameter int WIDTH = 32,
  parameter int AW    = 7
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [2**AW];

  // Write port and registered read port share one clocked process.
  // NOTE: non-blocking assignments make the read see the pre-write contents
  // and keep simulation order-independent; sequential state always uses <=.
  // NOTE: the array and read register have no reset on purpose, so the
  // storage maps onto block RAM; the parent never exposes unwritten data.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/stack_unit.sv
// LIFO stack with registered pop data, stall (hold) and flush (clear).
// Build option: define STACK_UNIT_ERR_EN to make err a sticky
// overflow/underflow flag; otherwise err is tied low.
module stack_unit
  import stack_unit_pkg::*;
#(
  parameter int WIDTH = STACK_WIDTH,
  parameter int DEPTH = STACK_DEPTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [WIDTH-1:0]         d,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     hold,
  input  logic                     clear,
  output logic [WIDTH-1:0]         q,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full,
  output logic                     err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] IDX_ONE  = AW'(1);

  logic [AW:0]      count_q, count_d;
  q_src_e           q_sel_q, q_sel_d;
  logic [WIDTH-1:0] q_reg_q, q_reg_d;

  logic             ram_we, ram_re;
  logic [AW-1:0]    ram_waddr, top_idx;
  logic [WIDTH-1:0] ram_rdata;
  op_e              op;

  assign op      = decode_op(push, pop);
  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_FULL);
  assign top_idx = count_q[AW-1:0] - IDX_ONE;   // wraps to DEPTH-1 when full

  // Operation decode: next count, RAM strobes and q source selection.
  // NOTE: every output gets a default first so no path leaves one unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    count_d   = count_q;
    q_sel_d   = q_sel_q;
    q_reg_d   = q_reg_q;
    ram_we    = 1'b0;
    ram_re    = 1'b0;
    ram_waddr = count_q[AW-1:0];
    if (clear) begin
      count_d = '0;
    end else if (!hold) begin
      unique case (op)
        OP_PUSH: begin
          if (!full) begin
            ram_we  = 1'b1;
            count_d = count_q + CNT_ONE;
          end
        end
        OP_POP: begin
          if (!empty) begin
            ram_re  = 1'b1;
            q_sel_d = Q_SRC_RAM;
            count_d = count_q - CNT_ONE;
          end else begin
            q_sel_d = Q_SRC_REG;
            q_reg_d = '0;
          end
        end
        OP_SWAP: begin
          if (!empty) begin
            ram_re    = 1'b1;
            ram_we    = 1'b1;
            ram_waddr = top_idx;
            q_sel_d   = Q_SRC_RAM;
          end else begin
            q_sel_d = Q_SRC_REG;
            q_reg_d = d;
          end
        end
        default: ;
      endcase
    end
  end

  // Count and q-source state; reset overrides every other input.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      q_sel_q <= Q_SRC_REG;
      q_reg_q <= '0;
    end else begin
      count_q <= count_d;
      q_sel_q <= q_sel_d;
      q_reg_q <= q_reg_d;
    end
  end

  stack_ram #(
    .WIDTH (WIDTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (d),
    .re    (ram_re),
    .raddr (top_idx),
    .rdata (ram_rdata)
  );

  assign q     = (q_sel_q == Q_SRC_RAM) ? ram_rdata : q_reg_q;
  assign count = count_q;

`ifdef STACK_UNIT_ERR_EN
  logic err_q;
  logic err_event;

  assign err_event = !hold && !clear &&
                     ((push && !pop && full) || (pop && !push && empty));

  // Sticky error: set on overflow/underflow, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset)          err_q <= 1'b0;
    else if (err_event) err_q <= 1'b1;
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: doc/stack_unit.md
STACK_UNIT -- requirements
Module: stack_unit

Interface
REQ-001 Parameter WIDTH, default 32, data word width in bits.
REQ-002 Parameter DEPTH, default 128, number of stack entries (power of two).
REQ-003 clk  input  1  system clock; all state changes on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 d  input  WIDTH  data to push.
REQ-006 push  input  1  push request from the control unit (qualified by hold).
REQ-007 pop  input  1  pop request from the control unit (qualified by hold).
REQ-008 hold  input  1  pipeline stall; freezes all state while high.
REQ-009 clear  input  1  synchronous flush of stack contents to empty.
REQ-010 q  output  WIDTH  registered popped data.
REQ-011 count  output  log2(DEPTH)+1  number of valid entries.
REQ-012 empty  output  1  high when count == 0.
REQ-013 full  output  1  high when count == DEPTH.
REQ-014 err  output  1  sticky overflow/underflow flag (see Configuration).

Function
REQ-015 Accepted operation = (push or pop) and not hold; hold high SHALL leave count, contents, q, err unchanged.
REQ-016 Push only, not full: write d to entry[count], count += 1 at the same edge; q unchanged.
REQ-017 Pop only, not empty: q <= entry[count-1] and count -= 1 at the same edge; q valid the cycle after the pop request (latency 1).
REQ-018 q SHALL hold its last value until the next accepted pop.
REQ-019 Push while full: write suppressed, count stays DEPTH, contents intact; overflow event.
REQ-020 Pop while empty: q <= 0, count stays 0; underflow event.
REQ-021 Push and pop in the same cycle, not empty: q <= entry[count-1], entry[count-1] <= d, count unchanged (replace top).
REQ-022 Push and pop in the same cycle, empty: q <= d (pass-through), count stays 0, no error.
REQ-023 clear SHALL set count to 0 and take priority over push/pop and hold in the same cycle; q and err unchanged by clear.
REQ-024 count SHALL never exceed DEPTH and never wrap below 0.
REQ-025 Entry storage is not reset; only count, q, err are.

Reset
REQ-026 reset high at a rising edge: count <= 0, q <= 0, err <= 0, overriding clear, hold, push, pop.
REQ-027 reset asserted mid-sequence SHALL discard all entries; first post-reset pop returns 0 with underflow.
REQ-028 After reset: empty = 1, full = 0.

Configuration
REQ-029 Macro STACK_UNIT_ERR_EN defined: err set on any overflow (REQ-019) or underflow (REQ-020) event, cleared only by reset.
REQ-030 Macro STACK_UNIT_ERR_EN undefined: err tied to 0, no error logic synthesized; REQ-019/REQ-020 data behaviour unchanged.

Structure
REQ-031 Shared package SHALL hold STACK_WIDTH, STACK_DEPTH and derived STACK_AW = log2(STACK_DEPTH) constants used as parameter defaults.
REQ-032 Storage SHALL be a sub-module stack_ram: single-clock synchronous RAM, one write port, one registered read port, inferable as block RAM.
REQ-033 stack_unit SHALL contain the count register, operation decode, q/err registers and flag logic.

Verification
REQ-034 Reset; push 0x11, 0x22, 0x33; pop x3 -> q = 0x33, 0x22, 0x11 on successive cycles; count 3->0; empty = 1.
REQ-035 Fill DEPTH=128 with 0..127; push 0xDEAD -> full = 1, count = 128, err = 1 (macro on) / 0 (off); pop -> q = 127.
REQ-036 Reset; pop -> q = 0, count = 0, err = 1 (macro on); second reset clears err.
REQ-037 Push 0xA; push+pop with d = 0xB -> q = 0xA, count = 1; pop -> q = 0xB. From empty, push+pop d = 0xC -> q = 0xC, count 0, err 0.
REQ-038 Push 0x5; pop with hold = 1 for 3 cycles -> q, count frozen; release -> q = 0x5 one cycle later.
REQ-039 Push 4 words; clear with push = 1 -> count = 0; reset during a pop burst -> q = 0, count = 0 next cycle.
